rx_stream_ctrl: RTL and testbench

Sequencer for the pattern byte source on the `clk_rx` domain. It drives the source's `en` input in programmable bursts with programmable gaps and absorbs the source's one-cycle read latency in a small FIFO. It presents the bytes downstream as a clean valid/ready stream and reports completion after a programmed total length. It sits between the pattern source and the receive-side consumer, so the consumer can apply backpressure.

---
 rtl/rx_stream_ctrl_if.sv | 39 +++
 rtl/rx_stream_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rx_stream_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_stream_ctrl_if.sv
// rx_stream_ctrl_if
//   Bundles the control, pattern-source and downstream-stream signals of
//   rx_stream_ctrl. The clock and reset stay as plain ports on the module.
//
//   master : the sequencer side (drives src_en, the m_* stream and status)
//   slave  : the surroundings (command, pattern source and consumer)
//
//   start, abort           command pulses
//   cfg_len/burst/gap      transfer configuration, latched at start
//   src_en / src_data      pattern source enable and its byte one cycle later
//   m_data/m_valid/m_ready downstream valid/ready stream
//   busy, done, byte_cnt   status
interface rx_stream_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] cfg_len;
    logic [7:0]       cfg_burst;
    logic [7:0]       cfg_gap;
    logic             src_en;
    logic [7:0]       src_data;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] byte_cnt;

    modport master (
        input  start, abort, cfg_len, cfg_burst, cfg_gap, src_data, m_ready,
        output src_en, m_data, m_valid, busy, done, byte_cnt
    );

    modport slave (
        output start, abort, cfg_len, cfg_burst, cfg_gap, src_data, m_ready,
        input  src_en, m_data, m_valid, busy, done, byte_cnt
    );
endinterface

// File: rtl/rx_stream_ctrl.sv
// rx_stream_ctrl
//   Sequences the pattern byte source on clk_rx: issues src_en in bursts
//   separated by idle gaps, catches each byte one cycle later in a small
//   FIFO and presents the FIFO head as a valid/ready stream. Reports done
//   once cfg_len bytes have been handed downstream; abort flushes and
//   returns to idle without done.
//
//   clk_rx  clock
//   rst_n   asynchronous active-low reset
//   bus     rx_stream_ctrl_if.master (command, config, source, stream, status)
module rx_stream_ctrl #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk_rx,
    input  logic             rst_n,
    rx_stream_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q, issued, byte_cnt_q;
    logic [7:0]       burst_q, gap_q, burst_cnt, gap_cnt;
    logic             pend;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, fill;
    logic [LEN_W-1:0] issued_inc;
    logic [7:0]       burst_cnt_inc;
    logic             pop, credit_ok, src_en_c;
    logic             load, flush, burst_wrap, gap_load;

    assign pop           = (count != '0) && bus.m_ready;
    assign issued_inc    = issued + LEN_W'(1);
    assign burst_cnt_inc = burst_cnt + 8'd1;
    // The in-flight byte already owns a slot; pops this cycle earn no credit.
    assign fill          = count + (AW+1)'(pend);
    assign credit_ok     = fill < FULL;

    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        src_en_c   = 1'b0;
        load       = 1'b0;
        flush      = 1'b0;
        burst_wrap = 1'b0;
        gap_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_len != '0) begin
                        load      = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    src_en_c = (issued < len_q) && credit_ok;
                    if (src_en_c) begin
                        if (issued_inc == len_q) begin
                            state_nxt = S_DRAIN;
                        end else if (burst_q != 8'd0 && burst_cnt_inc == burst_q) begin
                            burst_wrap = 1'b1;
                            if (gap_q != 8'd0) begin
                                gap_load  = 1'b1;
                                state_nxt = S_GAP;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (gap_cnt == 8'd1) begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                // Leave as the last byte is popped so done follows its handshake directly.
                end else if (!pend && (count == '0 || (count == (AW+1)'(1) && pop))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transfer configuration, captured at start
    always_ff @(posedge clk_rx) begin
        if (load) begin
            len_q   <= bus.cfg_len;
            burst_q <= bus.cfg_burst;
            gap_q   <= bus.cfg_gap;
        end
    end

    // Issue counters, in-flight flag, FIFO pointers and handshake count
    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            issued     <= '0;
            burst_cnt  <= 8'd0;
            gap_cnt    <= 8'd0;
            pend       <= 1'b0;
            byte_cnt_q <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            pend <= src_en_c;
            if (load) begin
                issued     <= '0;
                burst_cnt  <= 8'd0;
                byte_cnt_q <= '0;
            end else begin
                if (src_en_c) begin
                    issued    <= issued_inc;
                    burst_cnt <= burst_wrap ? 8'd0 : burst_cnt_inc;
                end
                if (pop) byte_cnt_q <= byte_cnt_q + LEN_W'(1);
            end
            if (gap_load)            gap_cnt <= gap_q;
            else if (state == S_GAP) gap_cnt <= gap_cnt - 8'd1;
            // Flush also drops the byte arriving from the last enable.
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (pend) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(pend) - (AW+1)'(pop);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk_rx) begin
        if (pend && !flush) mem[wr_ptr] <= bus.src_data;
    end

    a_no_overflow: assert property (@(posedge clk_rx) disable iff (!rst_n)
        !(pend && !flush && !pop && count == FULL));

    assign bus.src_en   = src_en_c;
    assign bus.m_valid  = (count != '0);
    assign bus.m_data   = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.byte_cnt = byte_cnt_q;
endmodule

// File: tb/tb_rx_stream_ctrl.sv
// tb_rx_stream_ctrl
//   Directed bench for rx_stream_ctrl with a pattern-source model (byte
//   pat(addr) one cycle after each src_en) and an occupancy model of the
//   FIFO used to check m_valid, the credit rule and byte order.
module tb_rx_stream_ctrl;
    localparam int DEPTH = 4;
    localparam int LEN_W = 16;

    logic clk_rx = 1'b0;
    logic rst_n  = 1'b0;

    rx_stream_ctrl_if #(.LEN_W(LEN_W)) bus();

    rx_stream_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_rx (clk_rx),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_rx = ~clk_rx;

    function automatic logic [7:0] pat(input int a);
        int t;
        t = a * 37 + 5;
        return t[7:0];
    endfunction

    // Pattern source: byte appears the cycle after its enable.
    logic [7:0] src_q = 8'h00;
    int         src_addr = 0;
    always @(posedge clk_rx) begin
        if (bus.src_en) begin
            src_q    <= pat(src_addr);
            src_addr <= src_addr + 1;
        end
    end
    assign bus.src_data = src_q;

    int n_chk = 0;
    int n_err = 0;
    int occ = 0, tb_pend = 0, exp_addr = 0;
    int hs_cnt = 0, en_cnt = 0, done_cnt = 0, full_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called once per cycle at the falling edge; inputs are stable until the next rising edge.
    task automatic mon();
        int hs;
        hs = (bus.m_valid && bus.m_ready) ? 1 : 0;
        chk("mvalid_vs_occ", bus.m_valid, occ != 0);
        chk("credit", bus.src_en && (occ + tb_pend >= DEPTH), 0);
        if (occ + tb_pend >= DEPTH) full_seen = 1;
        if (hs != 0) begin
            chk("data", bus.m_data, pat(exp_addr));
            exp_addr++;
            hs_cnt++;
        end
        if (bus.src_en) en_cnt++;
        if (bus.done) done_cnt++;
        occ     = occ + tb_pend - hs;
        tb_pend = bus.src_en ? 1 : 0;
    endtask

    task automatic begin_test();
        hs_cnt = 0; en_cnt = 0; done_cnt = 0; full_seen = 0;
    endtask

    task automatic cycle_end();
        @(posedge clk_rx);
        #1;
    endtask

    // Drives start so that it is sampled in "cycle 0"; returns at the start of cycle 1.
    task automatic kick(input int len, input int burst, input int gap);
        bus.cfg_len   = LEN_W'(len);
        bus.cfg_burst = 8'(burst);
        bus.cfg_gap   = 8'(gap);
        bus.start     = 1'b1;
        @(negedge clk_rx);
        mon();
        cycle_end();
        bus.start = 1'b0;
    endtask

    task automatic run_basic(input string tg);
        logic [2:0] e;
        begin_test();
        bus.m_ready = 1'b1;
        kick(8, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_rx);
            e = {(c >= 1 && c <= 8), (c >= 3 && c <= 10), (c == 11)};
            chk($sformatf("%s_en_vld_done_c%0d", tg, c), {bus.src_en, bus.m_valid, bus.done}, e);
            if (c == 11) chk({tg, "_byte_cnt"}, bus.byte_cnt, 8);
            if (c == 12) chk({tg, "_busy_end"}, bus.busy, 0);
            mon();
            cycle_end();
        end
        chk({tg, "_hs"}, hs_cnt, 8);
        chk({tg, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] e;
        int ok;
        bus.start = 1'b0; bus.abort = 1'b0; bus.m_ready = 1'b0;
        bus.cfg_len = '0; bus.cfg_burst = 8'd0; bus.cfg_gap = 8'd0;
        repeat (2) @(posedge clk_rx);
        #1;
        chk("rst_outputs", {bus.src_en, bus.m_valid, bus.m_data, bus.busy, bus.done, bus.byte_cnt}, 0);
        rst_n = 1'b1;
        cycle_end();

        // Basic: one byte per cycle, 3-cycle start latency, done right after last handshake
        run_basic("basic");

        // Bursts: 4 on / 3 off, last burst truncated; a start during the gap is ignored
        begin_test();
        bus.m_ready = 1'b1;
        kick(10, 4, 3);
        for (int c = 1; c <= 22; c++) begin
            bus.start   = (c == 5);
            bus.cfg_len = (c == 5) ? LEN_W'(0) : LEN_W'(10);
            @(negedge clk_rx);
            if (c <= 16)
                chk($sformatf("burst_en_c%0d", c), bus.src_en,
                    (c <= 4) || (c >= 8 && c <= 11) || (c >= 15));
            mon();
            cycle_end();
        end
        bus.start = 1'b0;
        chk("burst_byte_cnt", bus.byte_cnt, 10);
        chk("burst_en_cnt", en_cnt, 10);
        chk("burst_hs", hs_cnt, 10);
        chk("burst_done_cnt", done_cnt, 1);

        // Backpressure: ready 1,1,0,0,0 repeating
        begin_test();
        bus.m_ready = 1'b1;
        kick(16, 0, 0);
        ok = 0;
        for (int c = 1; c <= 200; c++) begin
            bus.m_ready = ((c % 5) < 2);
            @(negedge clk_rx);
            mon();
            cycle_end();
            if (done_cnt != 0) begin
                ok = 1;
                break;
            end
        end
        chk("bp_completed", ok, 1);
        chk("bp_fifo_filled", full_seen, 1);
        chk("bp_hs", hs_cnt, 16);
        chk("bp_en_cnt", en_cnt, 16);
        chk("bp_byte_cnt", bus.byte_cnt, 16);
        chk("bp_done_cnt", done_cnt, 1);
        bus.m_ready = 1'b1;

        // Zero length: straight to DONE
        begin_test();
        kick(0, 0, 0);
        @(negedge clk_rx);
        chk("zero_c1_busy_done_en", {bus.busy, bus.done, bus.src_en}, 3'b110);
        mon();
        cycle_end();
        @(negedge clk_rx);
        chk("zero_c2_busy_done", {bus.busy, bus.done}, 2'b00);
        mon();
        cycle_end();
        chk("zero_en_cnt", en_cnt, 0);

        // Abort after 5 handshakes
        begin_test();
        kick(20, 0, 0);
        ok = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_rx);
            mon();
            cycle_end();
            if (hs_cnt == 5) begin
                ok = 1;
                break;
            end
        end
        chk("abort_reached_5", ok, 1);
        bus.abort   = 1'b1;
        bus.m_ready = 1'b0;
        @(negedge clk_rx);
        chk("abort_src_en_same_cycle", bus.src_en, 0);
        chk("abort_busy_same_cycle", bus.busy, 1);
        mon();
        cycle_end();
        bus.abort = 1'b0;
        occ = 0; tb_pend = 0; exp_addr = src_addr;
        @(negedge clk_rx);
        chk("abort_next_vld_busy_done", {bus.m_valid, bus.busy, bus.done}, 3'b000);
        chk("abort_byte_cnt", bus.byte_cnt, 5);
        mon();
        cycle_end();
        bus.m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk_rx);
            mon();
            cycle_end();
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_busy", bus.busy, 0);

        // Asynchronous reset mid-run, then a clean transfer
        begin_test();
        kick(8, 0, 0);
        repeat (3) begin
            @(negedge clk_rx);
            mon();
            cycle_end();
        end
        @(negedge clk_rx);
        chk("rst_mid_busy_before", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {bus.src_en, bus.m_valid, bus.m_data, bus.busy, bus.done, bus.byte_cnt}, 0);
        cycle_end();
        rst_n = 1'b1;
        occ = 0; tb_pend = 0; exp_addr = src_addr;
        cycle_end();
        run_basic("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
